// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, a word-per-cycle clear engine and error strobes.
module sp_ram_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 12,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 wr_en,
    input  logic                 re_en,
    input  logic [WIDTH/8-1:0]   be,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 err
);

    localparam int NB = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Access handshake: an access is a cycle with wr_en or re_en high. It is
    // accepted only in IDLE with an in-range address; otherwise err pulses
    // on the following cycle. Accepted reads raise dout_valid one cycle later.
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              access, in_range, ok, do_wr, do_rd, clr_we;
    logic [WIDTH-1:0]  old_word, new_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_CLEAR: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                if (clr) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    assign busy = (state == S_CLEAR);

    always_comb begin
        access   = wr_en | re_en;
        in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
        ok       = (state == S_IDLE) && in_range;
        do_wr    = ok && wr_en;
        do_rd    = ok && re_en;
        clr_we   = rst && (state == S_CLEAR);
        old_word = mem[addr];
        new_word = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) new_word[8*k +: 8] = din[8*k +: 8];
        end
    end

    // Storage has no reset so it maps onto RAM primitives; the clear engine
    // zeroes it synchronously instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (do_wr) begin
            mem[addr] <= new_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            dout_valid <= do_rd;
            err        <= access && !ok;
            if (do_rd) begin
                dout <= (RDW_MODE != 0 && wr_en) ? new_word : old_word;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_param.sv
// Randomised scoreboard bench for sp_ram_param: two instances (read-first and
// write-first) share stimulus and are checked against a word-array model.
module tb_sp_ram_param;

    localparam int WIDTH = 16;
    localparam int DEPTH = 12;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              wr_en = 1'b0;
    logic              re_en = 1'b0;
    logic [1:0]        be = '0;
    logic [WIDTH-1:0]  din = '0;

    logic [WIDTH-1:0]  dout0, dout1;
    logic              dv0, dv1, busy0, busy1, err0, err1;

    always #5 clk = ~clk;

    sp_ram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .addr(addr), .wr_en(wr_en), .re_en(re_en),
        .be(be), .din(din), .dout(dout0), .dout_valid(dv0), .busy(busy0), .err(err0)
    );

    sp_ram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .addr(addr), .wr_en(wr_en), .re_en(re_en),
        .be(be), .din(din), .dout(dout1), .dout_valid(dv1), .busy(busy1), .err(err1)
    );

    // Scoreboard state
    typedef struct {
        logic             v;
        logic             e;
        logic             b;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
    } exp_t;

    exp_t             ctrl_q[$];
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    logic [WIDTH-1:0] m_mem [16];
    int               clear_left = DEPTH;
    logic [WIDTH-1:0] m_dout0 = '0;
    logic [WIDTH-1:0] m_dout1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic rd,
                        input logic [ADDR_W-1:0] a, input logic [1:0] b,
                        input logic [WIDTH-1:0] d);
        exp_t             e;
        logic [WIDTH-1:0] old_w, new_w;
        @(negedge clk);
        rst = r; clr = c; wr_en = w; re_en = rd; addr = a; be = b; din = d;
        e.v = 1'b0; e.e = 1'b0; e.b = 1'b0;
        if (!r) begin
            clear_left = DEPTH;
            m_dout0 = '0;
            m_dout1 = '0;
            e.b = 1'b1;
        end else if (clear_left > 0) begin
            e.e = w | rd;
            m_mem[DEPTH - clear_left] = '0;
            clear_left--;
            e.b = (clear_left > 0);
        end else begin
            if ((w | rd) && int'(a) >= DEPTH) begin
                e.e = 1'b1;
            end else if (w | rd) begin
                old_w = m_mem[a];
                new_w = old_w;
                if (w) begin
                    for (int k = 0; k < 2; k++)
                        if (b[k]) new_w[8*k +: 8] = d[8*k +: 8];
                    m_mem[a] = new_w;
                end
                if (rd) begin
                    e.v = 1'b1;
                    m_dout0 = old_w;
                    m_dout1 = new_w;
                    exp_q0.push_back(old_w);
                    exp_q1.push_back(new_w);
                end
            end
            if (c) clear_left = DEPTH;
            e.b = (clear_left > 0);
        end
        e.d0 = m_dout0;
        e.d1 = m_dout1;
        ctrl_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rd_word(input int a);
        step(1'b1, 1'b0, 1'b0, 1'b1, ADDR_W'(a), '0, '0);
    endtask

    task automatic wr_word(input int a, input logic [1:0] b, input logic [WIDTH-1:0] d);
        step(1'b1, 1'b0, 1'b1, 1'b0, ADDR_W'(a), b, d);
    endtask

    // Monitor: one control entry per driven cycle, data entries on dout_valid
    always @(posedge clk) begin
        exp_t             e;
        logic [WIDTH-1:0] x;
        #1;
        if (ctrl_q.size() > 0) begin
            e = ctrl_q.pop_front();
            chk("busy0", 32'(busy0), 32'(e.b));
            chk("busy1", 32'(busy1), 32'(e.b));
            chk("err0", 32'(err0), 32'(e.e));
            chk("err1", 32'(err1), 32'(e.e));
            chk("dout_valid0", 32'(dv0), 32'(e.v));
            chk("dout_valid1", 32'(dv1), 32'(e.v));
            chk("dout0_hold", 32'(dout0), 32'(e.d0));
            chk("dout1_hold", 32'(dout1), 32'(e.d1));
            if (dv0) begin
                if (exp_q0.size() == 0) chk("dout0_unexpected", 32'(dv0), 32'd0);
                else begin
                    x = exp_q0.pop_front();
                    chk("dout0_data", 32'(dout0), 32'(x));
                end
            end
            if (dv1) begin
                if (exp_q1.size() == 0) chk("dout1_unexpected", 32'(dv1), 32'd0);
                else begin
                    x = exp_q1.pop_front();
                    chk("dout1_data", 32'(dout1), 32'(x));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;

        // Reset and initial clear
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 2'b11, 16'h1111);
        idle(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) rd_word(a);

        // Byte-lane merge
        wr_word(5, 2'b11, 16'hA1B2);
        wr_word(5, 2'b01, 16'hFFFF);
        rd_word(5);
        wr_word(5, 2'b00, 16'h0000);
        rd_word(5);

        // Read-during-write
        wr_word(3, 2'b11, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 2'b11, 16'h5678);
        rd_word(3);

        // Out-of-range accesses
        rd_word(12);
        wr_word(15, 2'b11, 16'hDEAD);
        rd_word(11);

        // Fill, clear, access while busy
        for (int a = 0; a < DEPTH; a++) wr_word(a, 2'b11, 16'hBEEF);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        wr_word(4, 2'b11, 16'h4444);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, '0, '0);
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) rd_word(a);

        // Reset in the middle of a clear
        wr_word(7, 2'b11, 16'h7777);
        rd_word(7);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        idle(6);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, '0, '0);
        idle(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) rd_word(a);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ADDR_W'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 16'($urandom));
        end
        idle(DEPTH + 2);
        for (int a = 0; a < DEPTH; a++) rd_word(a);
        idle(3);

        chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sp_ram_param.md
Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM. It is the generalised successor of the team's fixed 16x8 RAM.
- Adds configurable width and depth (depth need not be a power of two), per-byte write enables, and a selectable read-during-write mode.
- Adds a hardware clear engine that zeroes the array one word per cycle, with a busy flag.
- Adds read-valid and error strobes. Sits between a bus master or FSM and local storage.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 12, number of words; any value >= 2.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.
- RDW_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new merged data).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous request to zero the whole array; sampled only in IDLE.
- addr  in  ADDR_W  word address.
- wr_en  in  1  write strobe.
- re_en  in  1  read strobe.
- be  in  WIDTH/8  byte enables; be[k] gates din[8k+7:8k].
- din  in  WIDTH  write data.
- dout  out  WIDTH  registered read data.
- dout_valid  out  1  one-cycle pulse; dout updated this cycle.
- busy  out  1  clear engine active; accesses ignored.
- err  out  1  one-cycle pulse on a rejected access.

Behaviour:
- Reset (rst=0, asynchronous):
  - dout=0, dout_valid=0, err=0.
  - FSM=CLEAR, clear counter=0, busy=1.
  - Array contents are not touched asynchronously.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, the next state is IDLE and busy falls at that same edge.
  - busy is therefore high for exactly DEPTH rising edges after rst deasserts.
  - IDLE with clr=1 -> CLEAR, cnt=0, busy=1 from the next edge. Any wr_en/re_en in that same cycle is still served.
  - clr while in CLEAR: ignored; no restart.
- Access while busy: wr_en or re_en high -> no array change, dout_valid=0, err=1 for one cycle, dout holds.
- Address range: addr >= DEPTH with wr_en or re_en -> write dropped, read returns no data (dout holds, dout_valid=0), err=1.
- Write (IDLE, in range, wr_en=1):
  - At the edge, each byte k with be[k]=1 takes din byte k; other bytes are unchanged.
  - be=0 gives a legal no-op write with no err.
- Read (IDLE, in range, re_en=1):
  - Latency 1. At edge N, dout <= mem[addr] and dout_valid=1 during cycle N+1 only.
  - dout holds its last value until the next successful read.
- wr_en=1 and re_en=1 together (legal; differs from the predecessor, which blocked both):
  - Write is performed.
  - dout gets the pre-write word if RDW_MODE=0, or the post-merge word if RDW_MODE=1.
  - dout_valid pulses.
- err and dout_valid are never high in the same cycle.
- Reset asserted mid-clear or mid-access: immediate return to reset state. The clear restarts from 0 after release; partial writes in flight are lost.
- Array must infer block/distributed RAM. Byte-lane writes are a per-lane loop; no full-array reset loop.

Test Plan:
- Release reset (WIDTH=16, DEPTH=12) -> busy=1 for exactly 12 edges, then 0. Reading addr 0..11 afterwards returns 0x0000 each, dout_valid one cycle after each re_en, err=0.
- Write addr 5, din=0xA1B2, be=2'b11; then addr 5, din=0xFFFF, be=2'b01; then read addr 5 -> dout=0xA1FF on the cycle after re_en.
- With mem[3]=0x1234, wr_en=re_en=1, addr 3, din=0x5678, be=2'b11 -> RDW_MODE=0 gives dout=0x1234, RDW_MODE=1 gives dout=0x5678. A following read returns 0x5678 in both modes.
- re_en at addr 12 and wr_en at addr 15 -> err=1 for one cycle each, dout_valid=0, dout unchanged. A read of addr 11 afterwards is unaffected.
- Fill all words with 0xBEEF, pulse clr for 1 cycle -> busy high 12 cycles. A write issued during busy gives err=1 and no effect. After busy falls, all words read 0x0000.
- Pull rst low at clear counter=6 -> busy stays high; after release, busy high for a full 12 cycles, dout=0, dout_valid=0 during reset.
